// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, forwards MEM/WB results
// into the ALU operands and inserts bubbles on load-use hazards and flushes.
module id_ex_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_alu_control,
    input  logic [2:0]      id_funct3,
    input  logic            id_alu_src,
    input  logic            id_alu_a_pc,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    input  logic            stall,
    input  logic            flush,
    output logic            load_use_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [1:0]      ex_alu_control,
    output logic [2:0]      ex_funct3,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [1:0]      alu_control;
        logic [2:0]      funct3;
        logic            alu_src;
        logic            alu_a_pc;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } id_ex_t;

    id_ex_t ex_q, ex_d, bubble, load;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] val,
        input logic [4:0]      m_rd,
        input logic            m_we,
        input logic [XLEN-1:0] m_val,
        input logic [4:0]      w_rd,
        input logic            w_we,
        input logic [XLEN-1:0] w_val
    );
        logic [XLEN-1:0] r;
        r = val;
        if (rs != 5'd0) begin
            if (m_we && m_rd == rs) r = m_val;
            else if (w_we && w_rd == rs) r = w_val;
        end
        return r;
    endfunction

    assign load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0)
                          & id_valid
                          & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
    end

    // WB bypass at capture covers the same-cycle regfile write/read case
    always_comb begin
        load             = '0;
        load.valid       = id_valid;
        load.pc          = id_pc;
        load.rs1         = id_rs1;
        load.rs2         = id_rs2;
        load.rd          = id_rd;
        load.rs1_data    = fwd(id_rs1, id_rs1_data, 5'd0, 1'b0, '0,
                               wb_rd, wb_reg_write, wb_result);
        load.rs2_data    = fwd(id_rs2, id_rs2_data, 5'd0, 1'b0, '0,
                               wb_rd, wb_reg_write, wb_result);
        load.imm         = id_imm;
        load.alu_control = id_alu_control;
        load.funct3      = id_funct3;
        load.alu_src     = id_alu_src;
        load.alu_a_pc    = id_alu_a_pc;
        load.reg_write   = id_reg_write & id_valid;
        load.mem_read    = id_mem_read & id_valid;
        load.mem_write   = id_mem_write & id_valid;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush)               ex_d = bubble;
        else if (stall)          ex_d = ex_q;
        else if (load_use_stall) ex_d = bubble;
        else                     ex_d = load;
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= bubble;
        else     ex_q <= ex_d;
    end

    assign fwd_rs1 = fwd(ex_q.rs1, ex_q.rs1_data, mem_rd, mem_reg_write,
                         mem_result, wb_rd, wb_reg_write, wb_result);
    assign fwd_rs2 = fwd(ex_q.rs2, ex_q.rs2_data, mem_rd, mem_reg_write,
                         mem_result, wb_rd, wb_reg_write, wb_result);

    assign ex_valid       = ex_q.valid;
    assign ex_pc          = ex_q.pc;
    assign ex_a           = ex_q.alu_a_pc ? ex_q.pc : fwd_rs1;
    assign ex_b           = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign ex_store_data  = fwd_rs2;
    assign ex_alu_control = ex_q.alu_control;
    assign ex_funct3      = ex_q.funct3;
    assign ex_rd          = ex_q.rd;
    assign ex_reg_write   = ex_q.reg_write & ex_q.valid;
    assign ex_mem_read    = ex_q.mem_read & ex_q.valid;
    assign ex_mem_write   = ex_q.mem_write & ex_q.valid;

endmodule
